reg_file_mp: RTL and testbench



---
 rtl/reg_file_mp.sv | 112 +++++++++++
 tb/tb_reg_file_mp.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with hardwired x0, pending scoreboard bits
// and a sequenced clear engine. Optional same-cycle write bypass: REG_FILE_MP_BYPASS_EN.
module reg_file_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRP  = 3
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [NRP*AW-1:0]   Ra,
  output logic [NRP*XLEN-1:0] busR,
  output logic [NRP-1:0]      Pend,
  input  logic [AW-1:0]       Rw,
  input  logic                RegWr,
  input  logic [XLEN-1:0]     busW,
  input  logic                Iss,
  input  logic [AW-1:0]       Rd,
  input  logic                Clr,
  output logic                ClrBusy
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [XLEN-1:0]     regs [NREG];
  logic [NREG-1:0]     pend_q;
  logic                wr_en, iss_en, sweep;

  // Writeback and issue are only honoured while idle; a sweep drops them.
  assign sweep   = (state_q == SWEEP);
  assign wr_en   = RegWr && (Rw != '0) && !sweep;
  assign iss_en  = Iss && (Rd != '0) && !sweep;
  assign ClrBusy = sweep;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (Clr) begin
          state_d = SWEEP;
          idx_d   = AW'(1);
        end
      end
      SWEEP: begin
        if (idx_q == AW'(NREG - 1)) begin
          state_d = IDLE;
          idx_d   = AW'(1);
        end else begin
          idx_d   = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = AW'(1);
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Register 0 is never targeted because wr_en/iss_en exclude address 0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
      pend_q <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (sweep && (idx_q == AW'(k))) begin
          regs[k]   <= '0;
          pend_q[k] <= 1'b0;
        end else begin
          if (wr_en && (Rw == AW'(k))) regs[k] <= busW;
          // A new producer issued in the same cycle as a writeback keeps the bit set.
          if (iss_en && (Rd == AW'(k)))     pend_q[k] <= 1'b1;
          else if (wr_en && (Rw == AW'(k))) pend_q[k] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = Ra[i*AW +: AW];

    always_comb begin
      busR[i*XLEN +: XLEN] = regs[addr];
      Pend[i]              = pend_q[addr];
`ifdef REG_FILE_MP_BYPASS_EN
      if (wr_en && (Rw == addr)) begin
        busR[i*XLEN +: XLEN] = busW;
        Pend[i]              = 1'b0;
      end
`endif
      if (addr == '0) begin
        busR[i*XLEN +: XLEN] = '0;
        Pend[i]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp at default parameters.
module tb_reg_file_mp;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [14:0] Ra;
  logic [95:0] busR;
  logic [2:0]  Pend;
  logic [4:0]  Rw;
  logic        RegWr;
  logic [31:0] busW;
  logic        Iss;
  logic [4:0]  Rd;
  logic        Clr;
  logic        ClrBusy;

  int checks = 0;
  int errors = 0;

  reg_file_mp dut (
    .Clk(Clk), .Rst_n(Rst_n), .Ra(Ra), .busR(busR), .Pend(Pend),
    .Rw(Rw), .RegWr(RegWr), .busW(busW), .Iss(Iss), .Rd(Rd),
    .Clr(Clr), .ClrBusy(ClrBusy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] prt(input int i);
    return busR[i*32 +: 32];
  endfunction

  task automatic setra(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    Ra = {a2, a1, a0};
  endtask

  initial begin
    int busy_cnt;
    Rst_n = 1'b0; Ra = '0; Rw = '0; RegWr = 1'b0; busW = '0;
    Iss = 1'b0; Rd = '0; Clr = 1'b0;

    // Reset state
    #2;
    setra(5'd0, 5'd5, 5'd31);
    #1;
    chk("rst_busy", {31'd0, ClrBusy}, 32'd0);
    chk("rst_p0", prt(0), 32'd0);
    chk("rst_p1", prt(1), 32'd0);
    chk("rst_p2", prt(2), 32'd0);
    chk("rst_pend", {29'd0, Pend}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // x0 is hardwired zero
    RegWr = 1'b1; Rw = 5'd0; busW = 32'hDEADBEEF;
    @(negedge Clk);
    RegWr = 1'b0; setra(5'd0, 5'd0, 5'd0);
    #1 chk("x0_read", prt(0), 32'd0);

    // Write then read on all ports
    RegWr = 1'b1; Rw = 5'd7; busW = 32'h12345678;
    @(negedge Clk);
    RegWr = 1'b0; setra(5'd7, 5'd7, 5'd7);
    #1;
    chk("x7_p0", prt(0), 32'h12345678);
    chk("x7_p1", prt(1), 32'h12345678);
    chk("x7_p2", prt(2), 32'h12345678);

    // Same-cycle write/read of x3
    setra(5'd3, 5'd7, 5'd0);
    RegWr = 1'b1; Rw = 5'd3; busW = 32'hA5A5A5A5;
    #1;
`ifdef REG_FILE_MP_BYPASS_EN
    chk("byp_same", prt(0), 32'hA5A5A5A5);
`else
    chk("byp_same", prt(0), 32'd0);
`endif
    @(negedge Clk);
    RegWr = 1'b0;
    #1 chk("byp_next", prt(0), 32'hA5A5A5A5);

    // Pending sequencing on x9
    setra(5'd9, 5'd0, 5'd0);
    Iss = 1'b1; Rd = 5'd9;
    #1 chk("pend_pre", {31'd0, Pend[0]}, 32'd0);
    @(negedge Clk);
    Iss = 1'b0;
    #1 chk("pend_iss", {31'd0, Pend[0]}, 32'd1);
    RegWr = 1'b1; Rw = 5'd9; busW = 32'h00001111;
    #1;
`ifdef REG_FILE_MP_BYPASS_EN
    chk("pend_wr_same", {31'd0, Pend[0]}, 32'd0);
`else
    chk("pend_wr_same", {31'd0, Pend[0]}, 32'd1);
`endif
    @(negedge Clk);
    RegWr = 1'b0;
    #1;
    chk("pend_wr", {31'd0, Pend[0]}, 32'd0);
    chk("x9_d1", prt(0), 32'h00001111);
    RegWr = 1'b1; Rw = 5'd9; busW = 32'h00002222; Iss = 1'b1; Rd = 5'd9;
    @(negedge Clk);
    RegWr = 1'b0; Iss = 1'b0;
    #1;
    chk("x9_d2", prt(0), 32'h00002222);
    chk("pend_both", {31'd0, Pend[0]}, 32'd1);
    Iss = 1'b1; Rd = 5'd0;
    @(negedge Clk);
    Iss = 1'b0; setra(5'd0, 5'd9, 5'd0);
    #1 chk("pend_x0", {31'd0, Pend[0]}, 32'd0);

    // Fill x1..x31
    for (int k = 1; k < 32; k++) begin
      RegWr = 1'b1; Rw = 5'(k); busW = 32'h100 + k;
      @(negedge Clk);
    end
    RegWr = 1'b0; setra(5'd31, 5'd9, 5'd1);
    #1;
    chk("fill_x31", prt(0), 32'h11F);
    chk("fill_x1", prt(2), 32'h101);
    chk("fill_pend9", {31'd0, Pend[1]}, 32'd0);

    // Clear sweep: reg k still holds its value until edge N+k clears it
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    for (int k = 1; k < 32; k++) begin
      setra(5'(k), 5'(k - 1), 5'd0);
      if (k == 5) begin RegWr = 1'b1; Rw = 5'd31; busW = 32'hFFFFFFFF; end
      if (k == 6) RegWr = 1'b0;
      if (k == 10) Clr = 1'b1;
      if (k == 11) Clr = 1'b0;
      #1;
      chk($sformatf("sw_busy%0d", k), {31'd0, ClrBusy}, 32'd1);
      chk($sformatf("sw_pre%0d", k), prt(0), 32'h100 + k);
      chk($sformatf("sw_post%0d", k - 1), prt(1), 32'd0);
      @(negedge Clk);
    end
    setra(5'd31, 5'd20, 5'd1);
    #1;
    chk("sw_done_busy", {31'd0, ClrBusy}, 32'd0);
    chk("sw_x31_drop", prt(0), 32'd0);
    chk("sw_x20", prt(1), 32'd0);

    // Reset in the middle of a sweep
    RegWr = 1'b1; Rw = 5'd20; busW = 32'h0000ABCD;
    @(negedge Clk);
    RegWr = 1'b0; Iss = 1'b1; Rd = 5'd25;
    @(negedge Clk);
    Iss = 1'b0; Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    repeat (9) @(negedge Clk);
    setra(5'd20, 5'd25, 5'd0);
    #1;
    chk("mid_busy", {31'd0, ClrBusy}, 32'd1);
    chk("mid_x20", prt(0), 32'h0000ABCD);
    chk("mid_pend25", {31'd0, Pend[1]}, 32'd1);
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, ClrBusy}, 32'd0);
    chk("mid_rst_x20", prt(0), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("post_x20", prt(0), 32'd0);
    chk("post_pend25", {31'd0, Pend[1]}, 32'd0);

    // New Clr accepted after reset; it runs the full length
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40 && ClrBusy; c++) begin
      busy_cnt++;
      @(negedge Clk);
    end
    chk("resweep_len", 32'(busy_cnt), 32'd31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
